// File: rtl/cu_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM states,
// datapath select codes and per-state static control bundle.
package cu_pkg;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_ANDI = 4'd3;
    localparam logic [3:0] OP_ADDI = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_LB   = 4'd6;
    localparam logic [3:0] OP_SW   = 4'd7;
    localparam logic [3:0] OP_BGT  = 4'd8;
    localparam logic [3:0] OP_BLT  = 4'd9;
    localparam logic [3:0] OP_BEQ  = 4'd10;
    localparam logic [3:0] OP_BNE  = 4'd11;
    localparam logic [3:0] OP_JMP  = 4'd12;
    localparam logic [3:0] OP_CALL = 4'd13;
    localparam logic [3:0] OP_RET  = 4'd14;
    localparam logic [3:0] OP_SV   = 4'd15;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;

    localparam logic [1:0] SRCPC_INC = 2'b00;
    localparam logic [1:0] SRCPC_BR  = 2'b01;
    localparam logic [1:0] SRCPC_JMP = 2'b10;
    localparam logic [1:0] SRCPC_RET = 2'b11;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC1 = 2'b10;

    typedef enum logic [2:0] {
        IC_ALU, IC_LOAD, IC_STORE, IC_BRANCH, IC_JMP, IC_CALL, IC_RET, IC_SV
    } iclass_t;

    typedef struct packed {
        logic       src_rw;
        logic       src_rb;
        logic       src_ra;
        logic       src_a;
        logic       src_b;
        logic [1:0] alu_op;
        logic       mem_add_src;
        logic       data_in_src;
        logic [1:0] wb;
        logic       take_ext1;
        logic       take_ext2;
        logic       byte_en;
    } ctrl_t;

    function automatic iclass_t op_class(input logic [3:0] op);
        iclass_t c;
        case (op)
            OP_LW, OP_LB:                    c = IC_LOAD;
            OP_SW:                           c = IC_STORE;
            OP_BGT, OP_BLT, OP_BEQ, OP_BNE:  c = IC_BRANCH;
            OP_JMP:                          c = IC_JMP;
            OP_CALL:                         c = IC_CALL;
            OP_RET:                          c = IC_RET;
            OP_SV:                           c = IC_SV;
            default:                         c = IC_ALU;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Static per-instruction datapath selects for the current FSM state; all
// selects are zero in states where the instruction does not use them.
module cu_decode
    import cu_pkg::*;
(
    input  state_t     state,
    input  logic [3:0] op,
    input  logic       mode,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_DECODE: begin
                if (op == OP_CALL) begin
                    ctrl.src_rw = 1'b1;
                    ctrl.wb     = WB_PC1;
                end
                if (op == OP_RET) ctrl.src_ra = 1'b1;
            end
            ST_EXEC: begin
                case (op)
                    OP_AND:  ctrl.alu_op = ALU_AND;
                    OP_ADD:  ctrl.alu_op = ALU_ADD;
                    OP_SUB:  ctrl.alu_op = ALU_SUB;
                    OP_ANDI: begin
                        ctrl.src_b  = 1'b1;
                        ctrl.alu_op = ALU_AND;
                    end
                    OP_ADDI, OP_LW, OP_LB, OP_SW: begin
                        ctrl.src_b  = 1'b1;
                        ctrl.alu_op = ALU_ADD;
                    end
                    // Branch compare: operand A chosen by mode, extended offset enabled
                    OP_BGT, OP_BLT, OP_BEQ, OP_BNE: begin
                        ctrl.src_a     = mode;
                        ctrl.src_rb    = 1'b1;
                        ctrl.alu_op    = ALU_SUB;
                        ctrl.take_ext1 = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                case (op)
                    OP_LB: begin
                        ctrl.byte_en   = 1'b1;
                        ctrl.take_ext2 = 1'b1;
                    end
                    OP_SW: ctrl.src_rb = 1'b1;
                    OP_SV: begin
                        ctrl.mem_add_src = 1'b1;
                        ctrl.data_in_src = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_WB: begin
                if (op == OP_LW || op == OP_LB) ctrl.wb = WB_MEM;
                else                            ctrl.wb = WB_ALU;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory handshake stall,
// timeout trap, write strobes and live-flag branch resolution.
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter int OPCODE_W    = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cu_enable,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mode,
    input  logic                zf,
    input  logic                nf,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                pc_w,
    output logic                ir_w,
    output logic [1:0]          src_pc,
    output logic                src_rw,
    output logic                src_rb,
    output logic                src_ra,
    output logic                src_a,
    output logic                src_b,
    output logic                reg_w,
    output logic                mem_w,
    output logic                mem_r,
    output logic [1:0]          alu_op,
    output logic                mem_add_src,
    output logic                data_in_src,
    output logic [1:0]          wb,
    output logic                take_ext1,
    output logic                take_ext2,
    output logic                byte_en,
    output logic                trap
);

    state_t          state_q, state_d, dec_state;
    logic [TO_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]      op_q, op_d, op_cur;
    logic            mode_q, mode_d, mode_cur;
    logic            illegal, timeout_hit, br_taken;
    iclass_t         cls;
    ctrl_t           ctrl;

    function automatic logic branch_taken(input logic [3:0] op, input logic z, input logic n);
        logic t;
        case (op)
            OP_BGT:  t = n & ~z;
            OP_BLT:  t = ~n & ~z;
            OP_BEQ:  t = z;
            OP_BNE:  t = ~z;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    generate
        if (OPCODE_W > 4) begin : g_wide_op
            assign illegal = |opcode[OPCODE_W-1:4];
        end else begin : g_narrow_op
            assign illegal = 1'b0;
        end
    endgenerate

    // The opcode register is loaded at the end of DECODE, so DECODE itself looks at the live input
    assign op_cur   = (state_q == ST_DECODE) ? opcode[3:0] : op_q;
    assign mode_cur = (state_q == ST_DECODE) ? mode : mode_q;
    assign cls      = op_class(op_cur);
    assign br_taken = branch_taken(op_q, zf, nf);
    assign cnt_inc  = cnt_q + TO_W'(1);
    assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_inc == TO_W'(MEM_TIMEOUT));
    assign dec_state = (state_q == ST_DECODE && illegal) ? ST_TRAP : state_q;

    cu_decode u_decode (
        .state (dec_state),
        .op    (op_cur),
        .mode  (mode_cur),
        .ctrl  (ctrl)
    );

    assign src_rw      = ctrl.src_rw;
    assign src_rb      = ctrl.src_rb;
    assign src_ra      = ctrl.src_ra;
    assign src_a       = ctrl.src_a;
    assign src_b       = ctrl.src_b;
    assign alu_op      = ctrl.alu_op;
    assign mem_add_src = ctrl.mem_add_src;
    assign data_in_src = ctrl.data_in_src;
    assign wb          = ctrl.wb;
    assign take_ext1   = ctrl.take_ext1;
    assign take_ext2   = ctrl.take_ext2;
    assign byte_en     = ctrl.byte_en;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        mode_d  = mode_q;
        cnt_d   = '0;
        mem_req = 1'b0;
        mem_r   = 1'b0;
        mem_w   = 1'b0;
        pc_w    = 1'b0;
        ir_w    = 1'b0;
        reg_w   = 1'b0;
        src_pc  = SRCPC_INC;
        trap    = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                mem_r   = 1'b1;
                if (mem_ready) begin
                    ir_w    = 1'b1;
                    pc_w    = 1'b1;
                    state_d = ST_DECODE;
                end else begin
                    cnt_d = cnt_inc;
                    if (timeout_hit) state_d = ST_TRAP;
                end
            end
            ST_DECODE: begin
                op_d   = opcode[3:0];
                mode_d = mode;
                if (illegal) begin
                    state_d = ST_TRAP;
                end else begin
                    case (cls)
                        IC_JMP, IC_CALL: begin
                            pc_w    = 1'b1;
                            src_pc  = SRCPC_JMP;
                            reg_w   = (cls == IC_CALL);
                            state_d = ST_FETCH;
                        end
                        IC_RET: begin
                            pc_w    = 1'b1;
                            src_pc  = SRCPC_RET;
                            state_d = ST_FETCH;
                        end
                        IC_SV:   state_d = ST_MEM;
                        default: state_d = ST_EXEC;
                    endcase
                end
            end
            ST_EXEC: begin
                case (cls)
                    IC_BRANCH: begin
                        if (br_taken) begin
                            pc_w   = 1'b1;
                            src_pc = SRCPC_BR;
                        end
                        state_d = ST_FETCH;
                    end
                    IC_LOAD, IC_STORE: state_d = ST_MEM;
                    default:           state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_r   = (cls == IC_LOAD);
                mem_w   = (cls != IC_LOAD);
                if (mem_ready) begin
                    state_d = (cls == IC_LOAD) ? ST_WB : ST_FETCH;
                end else begin
                    cnt_d = cnt_inc;
                    if (timeout_hit) state_d = ST_TRAP;
                end
            end
            ST_WB: begin
                reg_w   = 1'b1;
                state_d = ST_FETCH;
            end
            ST_TRAP: trap = 1'b1;
            default: state_d = ST_FETCH;
        endcase

        // Disabled (or being reset): freeze sequencing, suppress anything that writes or requests
        if (!cu_enable || !rst_n) begin
            state_d = state_q;
            op_d    = op_q;
            mode_d  = mode_q;
            cnt_d   = cnt_q;
            pc_w    = 1'b0;
            ir_w    = 1'b0;
            reg_w   = 1'b0;
            mem_w   = 1'b0;
            mem_req = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        op_q   <= op_d;
        mode_q <= mode_d;
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle output vectors checked
// against hand-derived expectations for each instruction class and corner case.
module tb_multicycle_control_unit;
    import cu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n, cu_enable, mode, zf, nf, mem_ready;
    logic [3:0] opcode;
    logic       mem_req, pc_w, ir_w, src_rw, src_rb, src_ra, src_a, src_b;
    logic       reg_w, mem_w, mem_r, mem_add_src, data_in_src;
    logic       take_ext1, take_ext2, byte_en, trap;
    logic [1:0] src_pc, alu_op, wb;

    typedef struct packed {
        logic       mem_req;
        logic       pc_w;
        logic       ir_w;
        logic [1:0] src_pc;
        logic       src_rw;
        logic       src_rb;
        logic       src_ra;
        logic       src_a;
        logic       src_b;
        logic       reg_w;
        logic       mem_w;
        logic       mem_r;
        logic [1:0] alu_op;
        logic       mem_add_src;
        logic       data_in_src;
        logic [1:0] wb;
        logic       take_ext1;
        logic       take_ext2;
        logic       byte_en;
        logic       trap;
    } ov_t;

    ov_t obs, e;
    int  checks = 0;
    int  errors = 0;

    multicycle_control_unit #(.OPCODE_W(4), .MEM_TIMEOUT(15), .TO_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .cu_enable(cu_enable), .opcode(opcode), .mode(mode),
        .zf(zf), .nf(nf), .mem_ready(mem_ready), .mem_req(mem_req), .pc_w(pc_w),
        .ir_w(ir_w), .src_pc(src_pc), .src_rw(src_rw), .src_rb(src_rb), .src_ra(src_ra),
        .src_a(src_a), .src_b(src_b), .reg_w(reg_w), .mem_w(mem_w), .mem_r(mem_r),
        .alu_op(alu_op), .mem_add_src(mem_add_src), .data_in_src(data_in_src), .wb(wb),
        .take_ext1(take_ext1), .take_ext2(take_ext2), .byte_en(byte_en), .trap(trap)
    );

    assign obs = {mem_req, pc_w, ir_w, src_pc, src_rw, src_rb, src_ra, src_a, src_b,
                  reg_w, mem_w, mem_r, alu_op, mem_add_src, data_in_src, wb,
                  take_ext1, take_ext2, byte_en, trap};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag);
        #1;
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    task automatic ex_fetch(input logic ready);
        e = '0;
        e.mem_req = 1'b1;
        e.mem_r   = 1'b1;
        if (ready) begin
            e.ir_w = 1'b1;
            e.pc_w = 1'b1;
        end
    endtask

    // Completes a zero-wait fetch of op and leaves the DUT in DECODE
    task automatic fetch_op(input logic [3:0] op, input logic md, input string tag);
        opcode    = op;
        mode      = md;
        mem_ready = 1'b1;
        ex_fetch(1'b1);
        chk({tag, "_fetch"});
        step();
        mem_ready = 1'b0;
    endtask

    task automatic run_branch(input logic [3:0] op, input logic md, input logic z,
                              input logic n, input logic taken, input string tag);
        fetch_op(op, md, tag);
        e = '0;
        chk({tag, "_decode"});
        zf = z;
        nf = n;
        step();
        e = '0;
        e.src_a     = md;
        e.src_rb    = 1'b1;
        e.alu_op    = ALU_SUB;
        e.take_ext1 = 1'b1;
        if (taken) begin
            e.pc_w   = 1'b1;
            e.src_pc = SRCPC_BR;
        end
        chk({tag, "_exec"});
        step();
        ex_fetch(1'b0);
        chk({tag, "_next_fetch"});
    endtask

    initial begin
        rst_n = 1'b0; cu_enable = 1'b1; mem_ready = 1'b0;
        opcode = OP_ADD; mode = 1'b0; zf = 1'b0; nf = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        ex_fetch(1'b0);
        chk("reset_fetch");

        // ADDI: FETCH, DECODE, EXEC, WB, next FETCH on cycle 5
        fetch_op(OP_ADDI, 1'b0, "addi");
        e = '0;
        chk("addi_decode");
        step();
        e = '0; e.src_b = 1'b1; e.alu_op = ALU_ADD;
        chk("addi_exec");
        step();
        e = '0; e.reg_w = 1'b1; e.wb = WB_ALU;
        chk("addi_wb");
        step();
        ex_fetch(1'b0);
        chk("addi_next_fetch");

        // LB with three memory wait cycles; opcode input changes after DECODE
        fetch_op(OP_LB, 1'b0, "lb");
        e = '0;
        chk("lb_decode");
        step();
        opcode = OP_JMP;
        e = '0; e.src_b = 1'b1; e.alu_op = ALU_ADD;
        chk("lb_exec");
        step();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            e = '0; e.mem_req = 1'b1; e.mem_r = 1'b1; e.byte_en = 1'b1; e.take_ext2 = 1'b1;
            chk("lb_mem");
            step();
        end
        mem_ready = 1'b0;
        e = '0; e.reg_w = 1'b1; e.wb = WB_MEM;
        chk("lb_wb");
        step();
        ex_fetch(1'b0);
        chk("lb_next_fetch");

        run_branch(OP_BEQ, 1'b1, 1'b1, 1'b0, 1'b1, "beq_taken");
        run_branch(OP_BEQ, 1'b0, 1'b0, 1'b0, 1'b0, "beq_not_taken");
        run_branch(OP_BGT, 1'b0, 1'b0, 1'b1, 1'b1, "bgt_taken");
        run_branch(OP_BLT, 1'b0, 1'b1, 1'b0, 1'b0, "blt_not_taken");
        run_branch(OP_BNE, 1'b1, 1'b0, 1'b1, 1'b1, "bne_taken");

        fetch_op(OP_CALL, 1'b0, "call");
        e = '0; e.pc_w = 1'b1; e.src_pc = SRCPC_JMP; e.reg_w = 1'b1; e.src_rw = 1'b1; e.wb = WB_PC1;
        chk("call_decode");
        step();
        ex_fetch(1'b0);
        chk("call_next_fetch");

        fetch_op(OP_RET, 1'b0, "ret");
        e = '0; e.pc_w = 1'b1; e.src_pc = SRCPC_RET; e.src_ra = 1'b1;
        chk("ret_decode");
        step();
        ex_fetch(1'b0);
        chk("ret_next_fetch");

        fetch_op(OP_JMP, 1'b0, "jmp");
        e = '0; e.pc_w = 1'b1; e.src_pc = SRCPC_JMP;
        chk("jmp_decode");
        step();

        // Sv goes straight from DECODE to MEM
        fetch_op(OP_SV, 1'b0, "sv");
        e = '0;
        chk("sv_decode");
        step();
        mem_ready = 1'b1;
        e = '0; e.mem_req = 1'b1; e.mem_w = 1'b1; e.mem_add_src = 1'b1; e.data_in_src = 1'b1;
        chk("sv_mem");
        step();
        mem_ready = 1'b0;
        ex_fetch(1'b0);
        chk("sv_next_fetch");

        // SW paused by cu_enable in MEM; mem_ready while disabled is ignored
        fetch_op(OP_SW, 1'b0, "sw");
        e = '0;
        chk("sw_decode");
        step();
        e = '0; e.src_b = 1'b1; e.alu_op = ALU_ADD;
        chk("sw_exec");
        step();
        e = '0; e.mem_req = 1'b1; e.mem_w = 1'b1; e.src_rb = 1'b1;
        chk("sw_mem_wait");
        step();
        cu_enable = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            e = '0; e.src_rb = 1'b1;
            chk("sw_mem_disabled");
            step();
        end
        cu_enable = 1'b1;
        mem_ready = 1'b0;
        e = '0; e.mem_req = 1'b1; e.mem_w = 1'b1; e.src_rb = 1'b1;
        chk("sw_mem_resume");
        step();
        mem_ready = 1'b1;
        chk("sw_mem_done");
        step();
        mem_ready = 1'b0;
        ex_fetch(1'b0);
        chk("sw_next_fetch");

        // Reset in EXEC of SUB aborts it: no WB follows
        fetch_op(OP_SUB, 1'b0, "sub");
        step();
        e = '0; e.alu_op = ALU_SUB;
        chk("sub_exec");
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        ex_fetch(1'b0);
        chk("abort_fetch");

        // Fetch timeout: 15 cycles of mem_ready low, then sticky trap
        for (int c = 1; c <= 15; c++) begin
            ex_fetch(1'b0);
            if (c == 1 || c == 15) chk("timeout_fetch_wait");
            step();
        end
        e = '0; e.trap = 1'b1;
        chk("trap_entered");
        mem_ready = 1'b1;
        opcode = OP_JMP;
        step();
        chk("trap_sticky");
        cu_enable = 1'b0;
        step();
        cu_enable = 1'b1;
        step();
        chk("trap_sticky_after_enable");
        mem_ready = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        ex_fetch(1'b0);
        chk("trap_cleared_by_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
